prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 18 +
 rtl/prog_addr_counter.sv | 36 +++
 rtl/prog_loader.sv | 104 ++++++++++
 tb/tb_prog_loader.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM states and word packing constants.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOW,
    HIGH,
    WRITE,
    DONE
  } state_e;

  localparam int BYTES_PER_WORD = 2;

  function automatic logic is_loading(input state_e s);
    return (s == LOW) || (s == HIGH) || (s == WRITE);
  endfunction

endpackage

// File: rtl/prog_addr_counter.sv
// Program memory write-address counter with clear, increment and terminal-count flag.
module prog_addr_counter #(
  parameter int Psize = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Psize-1:0] count_o,
  output logic             tc_o
);

  logic [Psize-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = &count_q;

endmodule

// File: rtl/prog_loader.sv
// Loads 2^Psize control words into program memory from a host byte stream, low byte first.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int Psize = 4,
  parameter int Csize = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       inData,
  input  logic             inValid,
  output logic             inReady,
  output logic             we,
  output logic [Psize-1:0] waddr,
  output logic [Csize-1:0] wdata,
  output logic             busy,
  output logic             done
);

  // Bits of the final byte that survive into the control word.
  localparam int HiBits = Csize - 8 * (BYTES_PER_WORD - 1);

  state_e              state_q, state_d;
  logic [7:0]          lo_q, lo_d;
  logic [HiBits-1:0]   hi_q, hi_d;
  logic                cnt_clr, cnt_inc, cnt_tc;
  logic [Psize-1:0]    cnt;
  logic                xfer;

  prog_addr_counter #(.Psize(Psize)) u_addr_counter (
    .clock   (clock),
    .reset   (reset),
    .clr_i   (cnt_clr),
    .inc_i   (cnt_inc),
    .count_o (cnt),
    .tc_o    (cnt_tc)
  );

  assign xfer = inValid && inReady;

  // NOTE: every output of this block is defaulted first so no path leaves a signal unassigned (no latches).
  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    inReady = 1'b0;
    we      = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOW;
          cnt_clr = 1'b1;
        end
      end
      LOW: begin
        inReady = 1'b1;
        if (xfer) begin
          lo_d    = inData;
          state_d = HIGH;
        end
      end
      HIGH: begin
        inReady = 1'b1;
        if (xfer) begin
          hi_d    = inData[HiBits-1:0];
          state_d = WRITE;
        end
      end
      WRITE: begin
        we = 1'b1;
        if (cnt_tc) begin
          state_d = DONE;
        end else begin
          cnt_inc = 1'b1;
          state_d = LOW;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the byte holding registers are reset too, so wdata reads 0 straight after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  // Address and data come straight from registers, so they are stable through the write pulse.
  assign waddr = cnt;
  assign wdata = {hi_q, lo_q};
  assign busy  = is_loading(state_q);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader with Psize=4, Csize=12.
module tb_prog_loader;

  localparam int Psize = 4;
  localparam int Csize = 12;
  localparam int Words = 1 << Psize;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [7:0]       inData = 8'h00;
  logic             inValid = 1'b0;
  logic             inReady;
  logic             we;
  logic [Psize-1:0] waddr;
  logic [Csize-1:0] wdata;
  logic             busy;
  logic             done;

  int compared   = 0;
  int mismatched = 0;

  logic [Psize-1:0] log_addr[$];
  logic [Csize-1:0] log_data[$];

  prog_loader #(.Psize(Psize), .Csize(Csize)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .inData  (inData),
    .inValid (inValid),
    .inReady (inReady),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (we === 1'b1) begin
      log_addr.push_back(waddr);
      log_data.push_back(wdata);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic note(input string name, input logic [31:0] got, input logic [31:0] exp);
    $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge just after the byte was taken.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    inData  = b;
    inValid = 1'b1;
    while (inReady !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (inReady !== 1'b1) begin
      compared++;
      mismatched++;
      note("send_byte_timeout", 32'(inReady), 32'h1);
    end
    @(negedge clock);
    inValid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    compared++;
    if ({inReady, we, waddr, wdata, busy, done} !== '0) begin
      mismatched++;
      $display("FAIL %s: inReady=%b we=%b waddr=0x%0h wdata=0x%0h busy=%b done=%b, all expected 0",
               tag, inReady, we, waddr, wdata, busy, done);
    end
  endtask

  function automatic logic [7:0] lo_byte(input int i);
    return 8'(8'h10 + i * 11);
  endfunction

  function automatic logic [7:0] hi_byte(input int i, input bit ff_first);
    if (ff_first && i == 0) return 8'hFF;
    return 8'(8'hC0 | i);
  endfunction

  // Full load from start; optionally pulses start during word start_word.
  task automatic do_full_load(input string tag, input int start_word, input bit ff_first);
    logic [Csize-1:0] exp;
    clear_log();
    pulse_start();
    for (int i = 0; i < Words; i++) begin
      if (i == start_word) start = 1'b1;
      send_byte(lo_byte(i));
      send_byte(hi_byte(i, ff_first));
      start = 1'b0;
    end
    @(negedge clock);
    @(negedge clock);
    compared++;
    if (log_addr.size() != Words) begin
      mismatched++;
      note({tag, "_write_count"}, 32'(log_addr.size()), 32'(Words));
    end else begin
      for (int i = 0; i < Words; i++) begin
        exp = {hi_byte(i, ff_first)[Csize-9:0], lo_byte(i)};
        compared++;
        if (log_addr[i] !== Psize'(i) || log_data[i] !== exp) begin
          mismatched++;
          $display("FAIL %s_word%0d: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                   tag, i, log_addr[i], log_data[i], i, exp);
        end
      end
    end
    compared++;
    if (done !== 1'b1 || busy !== 1'b0 || inReady !== 1'b0) begin
      mismatched++;
      $display("FAIL %s_done: done=%b busy=%b inReady=%b expected 1 0 0", tag, done, busy, inReady);
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    start   = 1'b1;
    inValid = 1'b1;
    inData  = 8'hA5;
    @(negedge clock);
    @(negedge clock);
    check_idle_outputs("reset_priority");
    reset   = 1'b0;
    start   = 1'b0;
    inValid = 1'b0;
    @(negedge clock);
    check_idle_outputs("reset_idle");
  endtask

  task automatic test_single_word();
    apply_reset();
    pulse_start();
    compared++;
    if (busy !== 1'b1 || inReady !== 1'b1 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL start_to_low: busy=%b inReady=%b done=%b expected 1 1 0", busy, inReady, done);
    end
    send_byte(8'h34);
    send_byte(8'h12);
    compared++;
    if (we !== 1'b1 || waddr !== 4'h0 || wdata !== 12'h234) begin
      mismatched++;
      $display("FAIL single_write: we=%b waddr=0x%0h wdata=0x%0h expected 1 0x0 0x234", we, waddr, wdata);
    end
    @(negedge clock);
    compared++;
    if (we !== 1'b0 || inReady !== 1'b1 || busy !== 1'b1 || waddr !== 4'h1) begin
      mismatched++;
      $display("FAIL after_write: we=%b inReady=%b busy=%b waddr=0x%0h expected 0 1 1 0x1",
               we, inReady, busy, waddr);
    end
    send_byte(8'hCD);
    send_byte(8'hAB);
    compared++;
    if (we !== 1'b1 || waddr !== 4'h1 || wdata !== 12'hBCD) begin
      mismatched++;
      $display("FAIL second_write: we=%b waddr=0x%0h wdata=0x%0h expected 1 0x1 0xbcd", we, waddr, wdata);
    end
    @(negedge clock);
  endtask

  task automatic test_stall();
    apply_reset();
    clear_log();
    inValid = 1'b1;
    inData  = 8'hEE;
    repeat (4) @(negedge clock);
    compared++;
    if (inReady !== 1'b0 || busy !== 1'b0 || log_addr.size() != 0) begin
      mismatched++;
      $display("FAIL idle_ignores_bytes: inReady=%b busy=%b writes=%0d expected 0 0 0",
               inReady, busy, log_addr.size());
    end
    inValid = 1'b0;
    pulse_start();
    send_byte(8'h56);
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      compared++;
      if (we !== 1'b0 || inReady !== 1'b1 || busy !== 1'b1) begin
        mismatched++;
        $display("FAIL stall_cycle%0d: we=%b inReady=%b busy=%b expected 0 1 1", c, we, inReady, busy);
      end
    end
    send_byte(8'h07);
    compared++;
    if (we !== 1'b1 || waddr !== 4'h0 || wdata !== 12'h756) begin
      mismatched++;
      $display("FAIL stall_write: we=%b waddr=0x%0h wdata=0x%0h expected 1 0x0 0x756", we, waddr, wdata);
    end
    @(negedge clock);
    @(negedge clock);
    compared++;
    if (log_addr.size() != 1) begin
      mismatched++;
      note("stall_write_count", 32'(log_addr.size()), 32'h1);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    do_full_load("full", -1, 1'b0);
    clear_log();
    inValid = 1'b1;
    inData  = 8'h55;
    repeat (8) @(negedge clock);
    inValid = 1'b0;
    compared++;
    if (log_addr.size() != 0 || done !== 1'b1) begin
      mismatched++;
      $display("FAIL no_wrap: writes=%0d done=%b expected 0 1", log_addr.size(), done);
    end
  endtask

  task automatic test_start_ignored();
    apply_reset();
    do_full_load("start_mid", 5, 1'b0);
  endtask

  task automatic test_reset_mid_load();
    apply_reset();
    clear_log();
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      send_byte(lo_byte(i));
      send_byte(hi_byte(i, 1'b0));
    end
    @(negedge clock);
    reset   = 1'b1;
    start   = 1'b1;
    inValid = 1'b1;
    inData  = 8'h99;
    @(negedge clock);
    check_idle_outputs("reset_mid_outputs");
    reset   = 1'b0;
    start   = 1'b0;
    inValid = 1'b0;
    repeat (4) @(negedge clock);
    compared++;
    if (log_addr.size() != 3 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid_writes: writes=%0d busy=%b expected 3 0", log_addr.size(), busy);
    end
    clear_log();
    pulse_start();
    send_byte(8'h21);
    send_byte(8'h03);
    @(negedge clock);
    compared++;
    if (log_addr.size() != 1 || log_addr[0] !== 4'h0 || log_data[0] !== 12'h321) begin
      mismatched++;
      $display("FAIL reload_after_reset: writes=%0d first addr/data expected 0x0/0x321", log_addr.size());
    end
  endtask

  task automatic test_discard_and_reload();
    apply_reset();
    do_full_load("first_load", -1, 1'b0);
    do_full_load("ff_reload", -1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_stall();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid_load();
    test_discard_and_reload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
